// File: rtl/axis_stream_generator_if.sv
// AXI4-Stream master/slave bundle used by axis_stream_generator.
// Carries TVALID/TREADY/TLAST/TDATA/TSTRB for one stream.
interface axis_stream_generator_if #(
  parameter int DATA_W = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;

  modport master (output tvalid, output tlast, output tdata, output tstrb, input tready);
  modport slave  (input tvalid, input tlast, input tdata, input tstrb, output tready);
endinterface

// File: rtl/axis_stream_generator.sv
// AXIS packet source: incrementing data words, TLAST per packet, idle gap between packets.
// Optional completed-packet counter enabled by defining AXIS_GEN_PKT_COUNTER_EN.
module axis_stream_generator #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_LEN_WIDTH          = 16,
  parameter int GAP_WIDTH              = 8,
  parameter int PKT_COUNT_WIDTH        = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  input  logic                              enable,
  input  logic [PKT_LEN_WIDTH-1:0]          pkt_len,
  input  logic [GAP_WIDTH-1:0]              gap,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] seed,
  output logic                              busy,
  output logic [PKT_COUNT_WIDTH-1:0]        pkt_count,
  input  logic                              pkt_count_reset,
  axis_stream_generator_if.master           m00_axis
);
  localparam int DW = C_M00_AXIS_TDATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [PKT_LEN_WIDTH-1:0] LEN_ONE  = 1;
  localparam logic [GAP_WIDTH-1:0]     GAP_ONE  = 1;
  localparam logic [DW-1:0]            DATA_ONE = 1;

  logic [1:0]               state_q, state_d;
  logic [DW-1:0]            tdata_q, tdata_d;
  logic [PKT_LEN_WIDTH-1:0] beat_q, beat_d;
  logic [PKT_LEN_WIDTH-1:0] len_q, len_d;
  logic [GAP_WIDTH-1:0]     gapl_q, gapl_d;
  logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;

  logic                     tvalid, tlast, hs;
  logic [PKT_LEN_WIDTH-1:0] len_in;

  // A zero-length request still produces a single-beat packet.
  assign len_in = (pkt_len == '0) ? LEN_ONE : pkt_len;

  assign tvalid = (state_q == SEND);
  assign tlast  = tvalid && (beat_q == (len_q - LEN_ONE));
  assign hs     = tvalid && m00_axis.tready;
  assign busy   = (state_q != IDLE);

  assign m00_axis.tvalid = tvalid;
  assign m00_axis.tlast  = tlast;
  assign m00_axis.tdata  = tdata_q;
  assign m00_axis.tstrb  = '1;

  always_comb begin
    state_d   = state_q;
    tdata_d   = tdata_q;
    beat_d    = beat_q;
    len_d     = len_q;
    gapl_d    = gapl_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SEND;
          tdata_d = seed;
          beat_d  = '0;
          len_d   = len_in;
          gapl_d  = gap;
        end
      end
      SEND: begin
        if (hs) begin
          tdata_d = tdata_q + DATA_ONE;
          if (tlast) begin
            beat_d = '0;
            if (gapl_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end else if (enable) begin
              len_d  = len_in;
              gapl_d = gap;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + LEN_ONE;
          end
        end
      end
      GAP: begin
        // Gap counter runs 0..gapl_q-1 so tvalid stays low for exactly gapl_q cycles.
        if (gap_cnt_q == (gapl_q - GAP_ONE)) begin
          if (enable) begin
            state_d = SEND;
            beat_d  = '0;
            len_d   = len_in;
            gapl_d  = gap;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= IDLE;
      tdata_q   <= '0;
      beat_q    <= '0;
      len_q     <= LEN_ONE;
      gapl_q    <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tdata_q   <= tdata_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      gapl_q    <= gapl_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef AXIS_GEN_PKT_COUNTER_EN
  logic [PKT_COUNT_WIDTH-1:0] pkt_count_q;
  localparam logic [PKT_COUNT_WIDTH-1:0] CNT_ONE = 1;

  // Clear wins over a coincident final-beat increment.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn)        pkt_count_q <= '0;
    else if (pkt_count_reset) pkt_count_q <= '0;
    else if (hs && tlast)     pkt_count_q <= pkt_count_q + CNT_ONE;
  end

  assign pkt_count = pkt_count_q;
`else
  logic unused_pkt_count_reset;
  assign unused_pkt_count_reset = pkt_count_reset;
  assign pkt_count              = '0;
`endif
endmodule
